// File: rtl/i2c_slave_regfile.sv
// I2C target fronting a byte-wide register file, oversampled in the clk domain.
// Supports a pointer write, then burst write or burst read with pointer auto-increment.
module i2c_slave_regfile #(
  parameter logic [6:0]  SLAVE_ADDR = 7'b1010001,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned PTR_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl,
  inout  wire              sda,
  input  logic             host_wr_en,
  input  logic [PTR_W-1:0] host_addr,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata,
  output logic             wr_strobe,
  output logic             rd_strobe,
  output logic [PTR_W-1:0] evt_ptr,
  output logic             busy,
  output logic             stop_det
);

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StWaitStop
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] evt_q, evt_d;
  logic             rw_q, rw_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             wr_stb_q, wr_stb_d;
  logic             rd_stb_q, rd_stb_d;
  logic             stop_q, stop_d;
  logic             reg_we;
  logic [7:0]       regs_q [NUM_REGS];

  logic scl_meta, scl_sync, scl_prev;
  logic sda_meta, sda_sync, sda_prev;
  logic scl_rise, scl_fall, start_cond, stop_cond;
  logic [7:0]       rx_byte;
  logic [PTR_W-1:0] ptr_inc;

  // Synchronizers reset to the idle bus level so reset itself never looks like START/STOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      {scl_meta, scl_sync, scl_prev} <= 3'b111;
      {sda_meta, sda_sync, sda_prev} <= 3'b111;
    end else begin
      {scl_meta, scl_sync, scl_prev} <= {scl, scl_meta, scl_sync};
      {sda_meta, sda_sync, sda_prev} <= {sda, sda_meta, sda_sync};
    end
  end

  assign scl_rise   = scl_sync & ~scl_prev;
  assign scl_fall   = ~scl_sync & scl_prev;
  assign start_cond = scl_sync & scl_prev & sda_prev & ~sda_sync;
  assign stop_cond  = scl_sync & scl_prev & ~sda_prev & sda_sync;
  assign rx_byte    = {shift_q[6:0], sda_sync};
  assign ptr_inc    = ptr_q + PTR_W'(1);

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    rw_d     = rw_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    evt_d    = evt_q;
    wr_stb_d = 1'b0;
    rd_stb_d = 1'b0;
    stop_d   = 1'b0;
    reg_we   = 1'b0;
    if (stop_cond) begin
      state_d = StIdle;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      stop_d  = 1'b1;
      cnt_d   = 4'd0;
    end else if (start_cond) begin
      state_d = StAddr;
      oe_d    = 1'b0;
      cnt_d   = 4'd0;
    end else begin
      unique case (state_q)
        StAddr, StPtr, StWdata: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              if (state_q == StAddr) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_d = StAddrAck;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = StWaitStop;
                  busy_d  = 1'b0;
                end
              end else if (state_q == StPtr) begin
                ptr_d   = rx_byte[PTR_W-1:0];
                state_d = StPtrAck;
              end else begin
                reg_we   = 1'b1;
                wr_stb_d = 1'b1;
                evt_d    = ptr_q;
                ptr_d    = ptr_inc;
                state_d  = StWdataAck;
              end
            end
          end
        end
        // First fall after the 8th bit starts the ACK, the next one ends it.
        StAddrAck, StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d = 1'b0;
              if (state_q == StAddrAck && rw_q) begin
                shift_d  = regs_q[ptr_q];
                oe_d     = ~regs_q[ptr_q][7];
                rd_stb_d = 1'b1;
                evt_d    = ptr_q;
                state_d  = StRdata;
              end else if (state_q == StAddrAck) begin
                state_d = StPtr;
              end else begin
                state_d = StWdata;
              end
            end
          end
        end
        StRdata: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              cnt_d   = 4'd0;
              state_d = StRdataAck;
            end else begin
              oe_d = ~shift_q[7];
            end
          end
        end
        StRdataAck: begin
          if (scl_rise) begin
            if (!sda_sync) begin
              ptr_d    = ptr_inc;
              shift_d  = regs_q[ptr_inc];
              rd_stb_d = 1'b1;
              evt_d    = ptr_inc;
              state_d  = StRdata;
            end else begin
              state_d = StWaitStop;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      shift_q  <= 8'h00;
      cnt_q    <= 4'd0;
      ptr_q    <= '0;
      evt_q    <= '0;
      rw_q     <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      wr_stb_q <= 1'b0;
      rd_stb_q <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      evt_q    <= evt_d;
      rw_q     <= rw_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      wr_stb_q <= wr_stb_d;
      rd_stb_q <= rd_stb_d;
      stop_q   <= stop_d;
    end
  end

  // A bus write wins over a host write to the same index in the same cycle.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (reset) begin
        regs_q[i] <= 8'h00;
      end else if (reg_we && ptr_q == PTR_W'(i)) begin
        regs_q[i] <= rx_byte;
      end else if (host_wr_en && host_addr == PTR_W'(i)) begin
        regs_q[i] <= host_wdata;
      end
    end
  end

  assign sda        = oe_q ? 1'b0 : 1'bz;
  assign host_rdata = regs_q[host_addr];
  assign wr_strobe  = wr_stb_q;
  assign rd_strobe  = rd_stb_q;
  assign evt_ptr    = evt_q;
  assign busy       = busy_q;
  assign stop_det   = stop_q;

endmodule
